mma_controller: RTL and testbench
=================================

# mma_controller

Top-level sequencer of the MMA (matrix-multiply accelerator) datapath. It accepts a start command, pulses per-loader configuration strobes and arbitrates the single shared ICB memory port among the IA, weight, bias, requant and OA engines. It launches IA/weight streaming into the systolic array once all operands are valid, counts finished tiles and reports completion through `sa_ready`.

## Interface
- REG_WIDTH, 32, width of `tile_count`
- clk  in  1  clock; all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- calc_start, cfg_16bits_ia  in  1  start pulse; IA precision select, sampled on start
- fifo_full_flag  in  1  downstream output FIFO full
- sa_ready  out  1  controller idle and ready for a new start
- icb_sel  out  3  current ICB owner
- init_cfg_ia / _weight / _bias / _requant / _oa  out  1 each  one-cycle config strobes
- use_16bits  out  1  latched `cfg_16bits_ia`
- tile_count  out  REG_WIDTH  tiles completed in the current run
- load_ia_req, load_weight_req, load_bias_req, load_quant_req, write_oa_req  in  1 each  ICB requests
- load_ia_granted, load_weight_granted, load_bias_granted, load_quant_granted, write_oa_granted  out  1 each  level grants
- send_ia_trigger, send_weight_trigger  out  1 each  streaming launch pulses
- ia_sending_done, weight_sending_done, ia_calc_done, write_done, oa_calc_over  in  1 each  engine status pulses
- ia_data_valid, weight_data_valid, bias_valid, quant_params_valid  in  1 each  operand-ready levels
- partial_sum_calc_over, tile_calc_over  in  1 each  compute-core pulses

## Operation
- FSM states: IDLE, INIT, CALC, DRAIN, DONE.
  - IDLE: `sa_ready`=1.
    - On `calc_start`, go to INIT.
    - On the same edge, latch `use_16bits` and clear `tile_count`.
  - INIT: lasts one cycle. All five `init_cfg_*` are 1. Then go to CALC.
  - CALC: issues triggers. On `ia_calc_done`, go to DRAIN.
  - DRAIN: wait until both sticky flags `oa_over_seen` and `write_done_seen` are set, then go to DONE.
  - DONE: lasts one cycle. Clears the sticky flags, then go to IDLE.
- `calc_start` is ignored outside IDLE.
- ICB arbiter:
  - Encoding: 0 none, 1 IA, 2 weight, 3 bias, 4 requant, 5 OA.
  - Arbitration occurs only when `icb_sel`=0.
  - Fixed priority: OA > bias > requant > weight > IA.
  - The owner's grant equals (`icb_sel`==owner).
  - Ownership is held until the owner's req is 0. At that point `icb_sel` returns to 0 for at least one cycle before the next grant.
  - The arbiter runs in every FSM state.
- Trigger rule, in CALC:
  - Condition: `!busy && ia_data_valid && weight_data_valid && bias_valid && quant_params_valid`.
  - When it holds, pulse `send_ia_trigger` and `send_weight_trigger` together for one cycle and set `busy`.
  - `busy` clears when both `ia_sending_done` and `weight_sending_done` have been seen. These are sticky per burst, in any order or in the same cycle.
- `tile_count` increments by 1 on each `tile_calc_over`, in any non-IDLE state. It wraps at 2^REG_WIDTH.
- `partial_sum_calc_over` is accepted but has no effect on state.
- Simultaneous `tile_calc_over` and DONE: the count still increments.

## Timing
- Reset values: state IDLE, `sa_ready`=1, `icb_sel`=0, all grants/triggers/`init_cfg_*`=0, `use_16bits`=0, `tile_count`=0, `busy` and sticky flags 0.
- All outputs are registered.
- Grant latency: req at edge N gives grant after edge N+1.
- Start to `init_cfg_*` high: 1 cycle.
- Operands valid to trigger: 1 cycle.
- Next trigger is no earlier than 1 cycle after the last sending-done.
- `rst` mid-run aborts immediately to reset values.

## Configuration
- `MMA_CTRL_BACKPRESSURE_EN` defined: `fifo_full_flag`=1 masks the trigger condition and blocks new IA/weight grants. Existing owners keep their grant.
- Not defined: `fifo_full_flag` is ignored.

## Structure
- `mma_ctrl_pkg`: FSM state enum, ICB_SEL_* localparams (0–5), default REG_WIDTH.
- Sub-module `mma_icb_arbiter`: five reqs in, `icb_sel` and five grants out.
- The FSM, trigger logic and counter stay in `mma_controller`.

## Test plan
- Reset then idle: `sa_ready`=1, `icb_sel`=0, `tile_count`=0.
- Start with `cfg_16bits_ia`=1: one cycle later all `init_cfg_*`=1 for exactly 1 cycle; `use_16bits`=1; `sa_ready`=0.
- `load_ia_req` and `write_oa_req` asserted together: `icb_sel`=5 first. After OA drops req, `icb_sel`=0 for 1 cycle, then 1.
- All four valids high: single-cycle dual trigger; no retrigger until both sending-done pulses arrive; retrigger 1 cycle later.
- 3 `tile_calc_over` pulses, then `ia_calc_done`, `oa_calc_over`, `write_done`: `tile_count`=3, DONE, `sa_ready`=1.
- With the macro defined and `fifo_full_flag`=1: no trigger despite valid operands; trigger 1 cycle after the flag drops.

Source files
------------

// File: rtl/mma_ctrl_pkg.sv
// Shared types and constants for the MMA controller: FSM states, ICB owner
// encodings and the default tile counter width.
package mma_ctrl_pkg;

  localparam int REG_WIDTH_DEFAULT = 32;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_INIT  = 3'd1,
    ST_CALC  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } ctrl_state_t;

  localparam logic [2:0] ICB_SEL_NONE   = 3'd0;
  localparam logic [2:0] ICB_SEL_IA     = 3'd1;
  localparam logic [2:0] ICB_SEL_WEIGHT = 3'd2;
  localparam logic [2:0] ICB_SEL_BIAS   = 3'd3;
  localparam logic [2:0] ICB_SEL_QUANT  = 3'd4;
  localparam logic [2:0] ICB_SEL_OA     = 3'd5;

  // One-hot grant vector for an owner code; bit order {oa, quant, bias, weight, ia}.
  function automatic logic [4:0] icb_grant_vec(input logic [2:0] sel);
    logic [4:0] v;
    v = 5'b00000;
    case (sel)
      ICB_SEL_IA:     v = 5'b00001;
      ICB_SEL_WEIGHT: v = 5'b00010;
      ICB_SEL_BIAS:   v = 5'b00100;
      ICB_SEL_QUANT:  v = 5'b01000;
      ICB_SEL_OA:     v = 5'b10000;
      default:        v = 5'b00000;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/mma_icb_arbiter.sv
// Single-port ICB arbiter: fixed priority OA > bias > requant > weight > IA,
// non-preemptive, with an idle cycle between owners. block_stream holds off new IA/weight grants.
module mma_icb_arbiter
  import mma_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       block_stream,
  input  logic       load_ia_req,
  input  logic       load_weight_req,
  input  logic       load_bias_req,
  input  logic       load_quant_req,
  input  logic       write_oa_req,
  output logic [2:0] icb_sel,
  output logic       load_ia_granted,
  output logic       load_weight_granted,
  output logic       load_bias_granted,
  output logic       load_quant_granted,
  output logic       write_oa_granted
);

  logic [4:0] req;
  logic [4:0] grant_q;
  logic [2:0] sel_next;
  logic       owner_req;

  assign req       = {write_oa_req, load_quant_req, load_bias_req, load_weight_req, load_ia_req};
  assign owner_req = |(req & icb_grant_vec(icb_sel));

  always_comb begin
    sel_next = icb_sel;
    if (icb_sel == ICB_SEL_NONE) begin
      if (req[4])                      sel_next = ICB_SEL_OA;
      else if (req[2])                 sel_next = ICB_SEL_BIAS;
      else if (req[3])                 sel_next = ICB_SEL_QUANT;
      else if (req[1] && !block_stream) sel_next = ICB_SEL_WEIGHT;
      else if (req[0] && !block_stream) sel_next = ICB_SEL_IA;
    end else if (!owner_req) begin
      // release always passes through NONE so the next owner waits a cycle
      sel_next = ICB_SEL_NONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      icb_sel <= ICB_SEL_NONE;
      grant_q <= 5'b00000;
    end else begin
      icb_sel <= sel_next;
      grant_q <= icb_grant_vec(sel_next);
    end
  end

  assign load_ia_granted     = grant_q[0];
  assign load_weight_granted = grant_q[1];
  assign load_bias_granted   = grant_q[2];
  assign load_quant_granted  = grant_q[3];
  assign write_oa_granted    = grant_q[4];

endmodule

// File: rtl/mma_controller.sv
// MMA datapath sequencer: start/config strobes, IA/weight launch, tile counting, ICB arbitration.
// Optional MMA_CTRL_BACKPRESSURE_EN: fifo_full_flag stalls launches and new IA/weight grants.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | sa_ready high, waiting for calc_start
// ST_INIT  | one cycle, all init_cfg_* strobes high
// ST_CALC  | launch IA/weight streams whenever operands are ready
// ST_DRAIN | wait for both oa_calc_over and write_done to have been seen
// ST_DONE  | one cycle, clear sticky flags and return to idle
module mma_controller
  import mma_ctrl_pkg::*;
#(
  parameter int REG_WIDTH = REG_WIDTH_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 calc_start,
  input  logic                 cfg_16bits_ia,
  input  logic                 fifo_full_flag,
  output logic                 sa_ready,
  output logic [2:0]           icb_sel,
  output logic                 init_cfg_ia,
  output logic                 init_cfg_weight,
  output logic                 init_cfg_bias,
  output logic                 init_cfg_requant,
  output logic                 init_cfg_oa,
  output logic                 use_16bits,
  output logic [REG_WIDTH-1:0] tile_count,
  input  logic                 load_ia_req,
  input  logic                 load_weight_req,
  input  logic                 load_bias_req,
  input  logic                 load_quant_req,
  input  logic                 write_oa_req,
  output logic                 load_ia_granted,
  output logic                 load_weight_granted,
  output logic                 load_bias_granted,
  output logic                 load_quant_granted,
  output logic                 write_oa_granted,
  output logic                 send_ia_trigger,
  output logic                 send_weight_trigger,
  input  logic                 ia_sending_done,
  input  logic                 weight_sending_done,
  input  logic                 ia_calc_done,
  input  logic                 write_done,
  input  logic                 oa_calc_over,
  input  logic                 ia_data_valid,
  input  logic                 weight_data_valid,
  input  logic                 bias_valid,
  input  logic                 quant_params_valid,
  input  logic                 partial_sum_calc_over,
  input  logic                 tile_calc_over
);

  ctrl_state_t state;
  logic [4:0]  init_cfg;
  logic        busy;
  logic        ia_done_seen;
  logic        wt_done_seen;
  logic        oa_over_seen;
  logic        write_done_seen;
  logic        stream_block;
  logic        unused_inputs;
  logic        operands_ready;
  logic        ia_seen_n;
  logic        wt_seen_n;

`ifdef MMA_CTRL_BACKPRESSURE_EN
  assign stream_block  = fifo_full_flag;
  assign unused_inputs = partial_sum_calc_over;
`else
  assign stream_block  = 1'b0;
  assign unused_inputs = partial_sum_calc_over ^ fifo_full_flag;
`endif

  assign operands_ready = ia_data_valid && weight_data_valid && bias_valid &&
                          quant_params_valid && !stream_block;
  assign ia_seen_n      = ia_done_seen | ia_sending_done;
  assign wt_seen_n      = wt_done_seen | weight_sending_done;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state               <= ST_IDLE;
      sa_ready            <= 1'b1;
      init_cfg            <= 5'b00000;
      use_16bits          <= 1'b0;
      tile_count          <= '0;
      send_ia_trigger     <= 1'b0;
      send_weight_trigger <= 1'b0;
      busy                <= 1'b0;
      ia_done_seen        <= 1'b0;
      wt_done_seen        <= 1'b0;
      oa_over_seen        <= 1'b0;
      write_done_seen     <= 1'b0;
    end else begin
      send_ia_trigger     <= 1'b0;
      send_weight_trigger <= 1'b0;
      init_cfg            <= 5'b00000;

      // both sending-done pulses may arrive in either order or together
      if (busy) begin
        if (ia_seen_n && wt_seen_n) begin
          busy         <= 1'b0;
          ia_done_seen <= 1'b0;
          wt_done_seen <= 1'b0;
        end else begin
          ia_done_seen <= ia_seen_n;
          wt_done_seen <= wt_seen_n;
        end
      end

      if (state != ST_IDLE) begin
        if (tile_calc_over) tile_count <= tile_count + REG_WIDTH'(1);
        if (oa_calc_over)   oa_over_seen <= 1'b1;
        if (write_done)     write_done_seen <= 1'b1;
      end

      case (state)
        ST_IDLE: begin
          if (calc_start) begin
            state        <= ST_INIT;
            sa_ready     <= 1'b0;
            use_16bits   <= cfg_16bits_ia;
            tile_count   <= '0;
            init_cfg     <= 5'b11111;
            busy         <= 1'b0;
            ia_done_seen <= 1'b0;
            wt_done_seen <= 1'b0;
          end
        end
        ST_INIT: state <= ST_CALC;
        ST_CALC: begin
          if (!busy && operands_ready) begin
            send_ia_trigger     <= 1'b1;
            send_weight_trigger <= 1'b1;
            busy                <= 1'b1;
          end
          if (ia_calc_done) state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (oa_over_seen && write_done_seen) state <= ST_DONE;
        end
        ST_DONE: begin
          oa_over_seen    <= 1'b0;
          write_done_seen <= 1'b0;
          sa_ready        <= 1'b1;
          state           <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign init_cfg_ia      = init_cfg[0];
  assign init_cfg_weight  = init_cfg[1];
  assign init_cfg_bias    = init_cfg[2];
  assign init_cfg_requant = init_cfg[3];
  assign init_cfg_oa      = init_cfg[4];

  mma_icb_arbiter u_arbiter (
    .clk                 (clk),
    .rst                 (rst),
    .block_stream        (stream_block),
    .load_ia_req         (load_ia_req),
    .load_weight_req     (load_weight_req),
    .load_bias_req       (load_bias_req),
    .load_quant_req      (load_quant_req),
    .write_oa_req        (write_oa_req),
    .icb_sel             (icb_sel),
    .load_ia_granted     (load_ia_granted),
    .load_weight_granted (load_weight_granted),
    .load_bias_granted   (load_bias_granted),
    .load_quant_granted  (load_quant_granted),
    .write_oa_granted    (write_oa_granted)
  );

endmodule

// File: tb/tb_mma_controller.sv
// Directed bench for mma_controller: arbiter vector table plus hand-written
// sequences for start, launch handshake, drain/done and backpressure.
module tb_mma_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic        calc_start, cfg_16bits_ia, fifo_full_flag;
  logic        sa_ready;
  logic [2:0]  icb_sel;
  logic        init_cfg_ia, init_cfg_weight, init_cfg_bias, init_cfg_requant, init_cfg_oa;
  logic        use_16bits;
  logic [31:0] tile_count;
  logic        load_ia_req, load_weight_req, load_bias_req, load_quant_req, write_oa_req;
  logic        load_ia_granted, load_weight_granted, load_bias_granted, load_quant_granted, write_oa_granted;
  logic        send_ia_trigger, send_weight_trigger;
  logic        ia_sending_done, weight_sending_done, ia_calc_done, write_done, oa_calc_over;
  logic        ia_data_valid, weight_data_valid, bias_valid, quant_params_valid;
  logic        partial_sum_calc_over, tile_calc_over;

  int pass_cnt  = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  mma_controller #(.REG_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .calc_start(calc_start), .cfg_16bits_ia(cfg_16bits_ia),
    .fifo_full_flag(fifo_full_flag), .sa_ready(sa_ready), .icb_sel(icb_sel),
    .init_cfg_ia(init_cfg_ia), .init_cfg_weight(init_cfg_weight), .init_cfg_bias(init_cfg_bias),
    .init_cfg_requant(init_cfg_requant), .init_cfg_oa(init_cfg_oa), .use_16bits(use_16bits),
    .tile_count(tile_count), .load_ia_req(load_ia_req), .load_weight_req(load_weight_req),
    .load_bias_req(load_bias_req), .load_quant_req(load_quant_req), .write_oa_req(write_oa_req),
    .load_ia_granted(load_ia_granted), .load_weight_granted(load_weight_granted),
    .load_bias_granted(load_bias_granted), .load_quant_granted(load_quant_granted),
    .write_oa_granted(write_oa_granted), .send_ia_trigger(send_ia_trigger),
    .send_weight_trigger(send_weight_trigger), .ia_sending_done(ia_sending_done),
    .weight_sending_done(weight_sending_done), .ia_calc_done(ia_calc_done),
    .write_done(write_done), .oa_calc_over(oa_calc_over), .ia_data_valid(ia_data_valid),
    .weight_data_valid(weight_data_valid), .bias_valid(bias_valid),
    .quant_params_valid(quant_params_valid), .partial_sum_calc_over(partial_sum_calc_over),
    .tile_calc_over(tile_calc_over)
  );

  // req bits {oa, quant, bias, weight, ia}; expected owner after one edge
  typedef struct {
    logic [4:0] req;
    logic [2:0] exp_sel;
  } arb_vec_t;

  arb_vec_t vecs[14];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s actual=%0h required=%0h", name, act, exp);
  endtask

  function automatic logic [4:0] exp_grants(input logic [2:0] sel);
    logic [4:0] g;
    g = 5'b00000;
    if (sel >= 3'd1 && sel <= 3'd5) g[sel - 3'd1] = 1'b1;
    return g;
  endfunction

  function automatic logic [4:0] act_grants();
    return {write_oa_granted, load_quant_granted, load_bias_granted,
            load_weight_granted, load_ia_granted};
  endfunction

  function automatic logic [4:0] act_init();
    return {init_cfg_oa, init_cfg_requant, init_cfg_bias, init_cfg_weight, init_cfg_ia};
  endfunction

  function automatic logic [1:0] act_trig();
    return {send_ia_trigger, send_weight_trigger};
  endfunction

  task automatic set_req(input logic [4:0] r);
    {write_oa_req, load_quant_req, load_bias_req, load_weight_req, load_ia_req} = r;
  endtask

  initial begin
    logic bp;
`ifdef MMA_CTRL_BACKPRESSURE_EN
    bp = 1'b1;
`else
    bp = 1'b0;
`endif
    vecs[0]  = '{5'b10001, 3'd5};
    vecs[1]  = '{5'b10001, 3'd5};
    vecs[2]  = '{5'b00001, 3'd0};
    vecs[3]  = '{5'b00001, 3'd1};
    vecs[4]  = '{5'b10001, 3'd1};
    vecs[5]  = '{5'b10000, 3'd0};
    vecs[6]  = '{5'b10000, 3'd5};
    vecs[7]  = '{5'b00000, 3'd0};
    vecs[8]  = '{5'b01110, 3'd3};
    vecs[9]  = '{5'b01010, 3'd0};
    vecs[10] = '{5'b01010, 3'd4};
    vecs[11] = '{5'b00010, 3'd0};
    vecs[12] = '{5'b00010, 3'd2};
    vecs[13] = '{5'b00000, 3'd0};

    rst = 1'b1;
    calc_start = 0; cfg_16bits_ia = 0; fifo_full_flag = 0;
    set_req(5'b00000);
    ia_sending_done = 0; weight_sending_done = 0; ia_calc_done = 0;
    write_done = 0; oa_calc_over = 0;
    ia_data_valid = 0; weight_data_valid = 0; bias_valid = 0; quant_params_valid = 0;
    partial_sum_calc_over = 0; tile_calc_over = 0;
    tick(); tick();
    rst = 1'b0;
    tick();

    chk("reset_sa_ready", 32'(sa_ready), 32'd1);
    chk("reset_icb_sel", 32'(icb_sel), 32'd0);
    chk("reset_tile_count", tile_count, 32'd0);
    chk("reset_use16", 32'(use_16bits), 32'd0);
    chk("reset_grants", 32'(act_grants()), 32'd0);
    chk("reset_init_cfg", 32'(act_init()), 32'd0);
    chk("reset_trig", 32'(act_trig()), 32'd0);

    for (int i = 0; i < 14; i++) begin
      set_req(vecs[i].req);
      tick();
      chk($sformatf("arb_sel[%0d]", i), 32'(icb_sel), 32'(vecs[i].exp_sel));
      chk($sformatf("arb_grant[%0d]", i), 32'(act_grants()), 32'(exp_grants(vecs[i].exp_sel)));
    end
    set_req(5'b00000);

    // start with 16-bit IA
    calc_start = 1; cfg_16bits_ia = 1;
    tick();
    calc_start = 0; cfg_16bits_ia = 0;
    chk("start_init_cfg", 32'(act_init()), 32'h1f);
    chk("start_use16", 32'(use_16bits), 32'd1);
    chk("start_sa_ready", 32'(sa_ready), 32'd0);
    tick();
    chk("init_cfg_one_cycle", 32'(act_init()), 32'd0);

    // launch handshake in CALC
    ia_data_valid = 1; weight_data_valid = 1; bias_valid = 1; quant_params_valid = 1;
    tick();
    chk("trig_first", 32'(act_trig()), 32'd3);
    tick();
    chk("trig_single_cycle", 32'(act_trig()), 32'd0);
    tick();
    chk("trig_busy_hold", 32'(act_trig()), 32'd0);
    ia_sending_done = 1; tick(); ia_sending_done = 0;
    chk("trig_after_ia_done", 32'(act_trig()), 32'd0);
    tick();
    chk("trig_wait_weight", 32'(act_trig()), 32'd0);
    weight_sending_done = 1; tick(); weight_sending_done = 0;
    chk("trig_at_last_done", 32'(act_trig()), 32'd0);
    tick();
    chk("retrig", 32'(act_trig()), 32'd3);
    ia_sending_done = 1; weight_sending_done = 1; tick();
    ia_sending_done = 0; weight_sending_done = 0;
    chk("trig_same_cycle_done", 32'(act_trig()), 32'd0);
    tick();
    chk("retrig_same_cycle", 32'(act_trig()), 32'd3);

    calc_start = 1; cfg_16bits_ia = 0; tick(); calc_start = 0;
    chk("start_ignored_use16", 32'(use_16bits), 32'd1);
    chk("start_ignored_init", 32'(act_init()), 32'd0);

    // tiles, drain, done
    for (int t = 0; t < 3; t++) begin
      tile_calc_over = 1; tick(); tile_calc_over = 0; tick();
    end
    chk("tile_count_3", tile_count, 32'd3);
    ia_calc_done = 1; tick(); ia_calc_done = 0;
    oa_calc_over = 1; tick(); oa_calc_over = 0;
    tick();
    chk("drain_wait_write", 32'(sa_ready), 32'd0);
    write_done = 1; tick(); write_done = 0;
    chk("drain_flags_set", 32'(sa_ready), 32'd0);
    tick();
    chk("done_state", 32'(sa_ready), 32'd0);
    tile_calc_over = 1; tick(); tile_calc_over = 0;
    chk("idle_after_done", 32'(sa_ready), 32'd1);
    chk("tile_count_at_done", tile_count, 32'd4);

    // backpressure run
    calc_start = 1; cfg_16bits_ia = 1; tick(); calc_start = 0; cfg_16bits_ia = 0;
    chk("restart_tile_clear", tile_count, 32'd0);
    tick();
    fifo_full_flag = 1; set_req(5'b00010);
    tick();
    chk("bp_trig_masked", 32'(act_trig()), bp ? 32'd0 : 32'd3);
    chk("bp_weight_blocked", 32'(icb_sel), bp ? 32'd0 : 32'd2);
    tick();
    chk("bp_trig_still_off", 32'(act_trig()), 32'd0);
    fifo_full_flag = 0;
    tick();
    chk("bp_trig_after_drop", 32'(act_trig()), bp ? 32'd3 : 32'd0);
    chk("bp_weight_granted", 32'(icb_sel), 32'd2);
    tile_calc_over = 1; tick(); tile_calc_over = 0;
    chk("run2_tile", tile_count, 32'd1);

    // asynchronous abort
    rst = 1'b1;
    #2;
    chk("abort_sa_ready", 32'(sa_ready), 32'd1);
    chk("abort_icb_sel", 32'(icb_sel), 32'd0);
    chk("abort_tile_count", tile_count, 32'd0);
    chk("abort_use16", 32'(use_16bits), 32'd0);
    chk("abort_grants", 32'(act_grants()), 32'd0);
    set_req(5'b00000);
    tick();
    rst = 1'b0;
    tick();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
